// File: rtl/pipe_fifo.sv
// First-word-fall-through circular FIFO with valid/ready on both sides.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module pipe_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    assign empty = (head == tail);
    assign full  = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

    // Ready never looks at deq_ready, so a full FIFO refuses enq even while popping.
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem[head_idx];
    assign count     = tail - head;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so deq_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire && !flush) begin
            mem[tail_idx] <= enq_data;
        end
    end

endmodule

// File: tb/tb_pipe_fifo.sv
// Directed self-checking bench for pipe_fifo (WIDTH=32, DEPTH=8).
module tb_pipe_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst_aL;
    logic              flush;
    logic              enq_valid;
    logic [WIDTH-1:0]  enq_data;
    logic              enq_ready;
    logic              deq_valid;
    logic [WIDTH-1:0]  deq_data;
    logic              deq_ready;
    logic [3:0]        count;

    int pass_cnt;
    int total_cnt;

    pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_aL    = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b1;
        enq_data  = 32'hA5;
        deq_ready = 1'b0;
        #2;
        total_cnt++;
        if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b want 1", enq_ready);
        else pass_cnt++;
        total_cnt++;
        if (deq_valid !== 1'b0) $display("FAIL reset_deq_valid: got %b want 0", deq_valid);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
        else pass_cnt++;
        total_cnt++;
        if (deq_data !== 32'h0) $display("FAIL reset_deq_data: got %h want 0", deq_data);
        else pass_cnt++;
        // Edges while held in reset must not enqueue.
        step();
        step();
        total_cnt++;
        if (count !== 4'd0) $display("FAIL reset_hold_count: got %0d want 0", count);
        else pass_cnt++;
        rst_aL = 1'b1;
        step();
        enq_valid = 1'b0;
        total_cnt++;
        if (deq_data !== 32'hA5) $display("FAIL reset_first_enq_data: got %h want a5", deq_data);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd1) $display("FAIL reset_first_enq_count: got %0d want 1", count);
        else pass_cnt++;
        total_cnt++;
        if (deq_valid !== 1'b1) $display("FAIL reset_first_enq_valid: got %b want 1", deq_valid);
        else pass_cnt++;
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL reset_drain_count: got %0d want 0", count);
        else pass_cnt++;
    endtask

    task automatic test_fill_order();
        deq_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            enq_valid = 1'b1;
            enq_data  = i;
            step();
        end
        total_cnt++;
        if (count !== 4'd8) $display("FAIL fill_count: got %0d want 8", count);
        else pass_cnt++;
        total_cnt++;
        if (enq_ready !== 1'b0) $display("FAIL fill_enq_ready: got %b want 0", enq_ready);
        else pass_cnt++;
        enq_data = 32'h99;
        step();
        enq_valid = 1'b0;
        total_cnt++;
        if (count !== 4'd8) $display("FAIL fill_ninth_count: got %0d want 8", count);
        else pass_cnt++;
        deq_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total_cnt++;
            if (deq_valid !== 1'b1 || deq_data !== i)
                $display("FAIL fill_order[%0d]: got valid=%b data=%h want valid=1 data=%h",
                         i, deq_valid, deq_data, i);
            else pass_cnt++;
            step();
        end
        deq_ready = 1'b0;
        total_cnt++;
        if (deq_valid !== 1'b0) $display("FAIL fill_drained_valid: got %b want 0", deq_valid);
        else pass_cnt++;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL fill_drained_count: got %0d want 0", count);
        else pass_cnt++;
    endtask

    task automatic test_full_simul();
        logic [WIDTH-1:0] exp_q [9];
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'h10 + i;
            step();
        end
        total_cnt++;
        if (count !== 4'd8) $display("FAIL fullsim_count_pre: got %0d want 8", count);
        else pass_cnt++;
        enq_data  = 32'hEE;
        deq_ready = 1'b1;
        step();
        total_cnt++;
        if (count !== 4'd7) $display("FAIL fullsim_count_post: got %0d want 7", count);
        else pass_cnt++;
        total_cnt++;
        if (deq_data !== 32'h11) $display("FAIL fullsim_head_post: got %h want 11", deq_data);
        else pass_cnt++;
        deq_ready = 1'b0;
        enq_data  = 32'hEF;
        total_cnt++;
        if (enq_ready !== 1'b1) $display("FAIL fullsim_enq_ready: got %b want 1", enq_ready);
        else pass_cnt++;
        step();
        enq_valid = 1'b0;
        total_cnt++;
        if (count !== 4'd8) $display("FAIL fullsim_refill_count: got %0d want 8", count);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) exp_q[i] = 32'h11 + i;
        exp_q[7] = 32'hEF;
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (deq_valid !== 1'b1 || deq_data !== exp_q[i])
                $display("FAIL fullsim_order[%0d]: got valid=%b data=%h want valid=1 data=%h",
                         i, deq_valid, deq_data, exp_q[i]);
            else pass_cnt++;
            step();
        end
        deq_ready = 1'b0;
        total_cnt++;
        if (deq_valid !== 1'b0) $display("FAIL fullsim_drained: got %b want 0", deq_valid);
        else pass_cnt++;
    endtask

    task automatic test_stream_wrap();
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'h100 + i;
            step();
        end
        deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            enq_data = 32'h103 + k;
            total_cnt++;
            if (deq_valid !== 1'b1 || deq_data !== 32'h100 + k || count !== 4'd3)
                $display("FAIL stream[%0d]: got data=%h count=%0d want data=%h count=3",
                         k, deq_data, count, 32'h100 + k);
            else pass_cnt++;
            step();
        end
        enq_valid = 1'b0;
        for (int k = 20; k < 23; k++) begin
            total_cnt++;
            if (deq_valid !== 1'b1 || deq_data !== 32'h100 + k)
                $display("FAIL stream_tail[%0d]: got valid=%b data=%h want valid=1 data=%h",
                         k, deq_valid, deq_data, 32'h100 + k);
            else pass_cnt++;
            step();
        end
        deq_ready = 1'b0;
        total_cnt++;
        if (count !== 4'd0) $display("FAIL stream_drained_count: got %0d want 0", count);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic saw_77;
        saw_77 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'h50 + i;
            step();
        end
        total_cnt++;
        if (count !== 4'd5) $display("FAIL flush_pre_count: got %0d want 5", count);
        else pass_cnt++;
        flush     = 1'b1;
        enq_data  = 32'h77;
        deq_ready = 1'b1;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        total_cnt++;
        if (count !== 4'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1)
            $display("FAIL flush_state: got count=%0d deq_valid=%b enq_ready=%b want 0/0/1",
                     count, deq_valid, enq_ready);
        else pass_cnt++;
        enq_valid = 1'b1;
        enq_data  = 32'h88;
        step();
        enq_valid = 1'b0;
        total_cnt++;
        if (deq_data !== 32'h88 || count !== 4'd1)
            $display("FAIL flush_next_enq: got data=%h count=%0d want 88/1", deq_data, count);
        else pass_cnt++;
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (deq_valid && deq_data == 32'h77) saw_77 = 1'b1;
            step();
        end
        deq_ready = 1'b0;
        total_cnt++;
        if (saw_77 !== 1'b0 || deq_valid !== 1'b0)
            $display("FAIL flush_no_77: got saw77=%b deq_valid=%b want 0/0", saw_77, deq_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'h40 + i;
            step();
        end
        enq_valid = 1'b0;
        total_cnt++;
        if (count !== 4'd4) $display("FAIL rstmid_pre_count: got %0d want 4", count);
        else pass_cnt++;
        #2;
        rst_aL = 1'b0;
        #1;
        total_cnt++;
        if (count !== 4'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1)
            $display("FAIL rstmid_async: got count=%0d deq_valid=%b enq_ready=%b want 0/0/1",
                     count, deq_valid, enq_ready);
        else pass_cnt++;
        total_cnt++;
        if (deq_data !== 32'h0) $display("FAIL rstmid_data: got %h want 0", deq_data);
        else pass_cnt++;
        #1;
        rst_aL    = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 32'h3C;
        step();
        enq_valid = 1'b0;
        total_cnt++;
        if (deq_data !== 32'h3C || count !== 4'd1 || deq_valid !== 1'b1)
            $display("FAIL rstmid_after: got data=%h count=%0d valid=%b want 3c/1/1",
                     deq_data, count, deq_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_fill_order();
        test_full_simul();
        test_stream_wrap();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
